banked_instruction_memory: RTL and testbench
============================================

Name: banked_instruction_memory

Overview:
- Parametrised, writable, multi-bank program store feeding the CPU fetch stage.
- Holds NUM_BANKS independent programs of DEPTH words each.
- Selects the program with a lowest-index-wins priority encode. The selection is latched at start and held until halt.
- Serves fetches with a registered one-cycle read, and accepts program loads through a write port with acknowledge/reject.

Parameters:
INSTR_WIDTH, 16, instruction word width
ADDR_WIDTH, 8, fetch/write address width
DEPTH, 128, words per bank (DEPTH <= 2**ADDR_WIDTH)
NUM_BANKS, 8, number of program banks (>= 2)
HALT_WORD, 16'hE000, word returned on any faulted fetch (opcode 1110 = HALT)

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
programSelect  in  NUM_BANKS  one bit per bank; lowest set bit wins
start  in  1  pulse: latch selected bank, enter RUN
halt  in  1  pulse: release bank, return to IDLE
fetchReq  in  1  fetch strobe
fetchAddr  in  ADDR_WIDTH  fetch address
instruction  out  INSTR_WIDTH  registered fetched word
instrValid  out  1  one-cycle pulse, instruction valid
fetchFault  out  1  qualifies instrValid: word is HALT_WORD due to fault
running  out  1  high in RUN
activeBank  out  clog2(NUM_BANKS)  latched bank index
noProgram  out  1  one-cycle pulse: start with no select bit set
wrEn  in  1  write strobe
wrBank  in  clog2(NUM_BANKS)  target bank
wrAddr  in  ADDR_WIDTH  target word
wrData  in  INSTR_WIDTH  data
wrAck  out  1  one-cycle pulse, write committed
wrReject  out  1  one-cycle pulse, write dropped

Behaviour:
- Reset (rstN low, async):
  - State goes to IDLE.
  - instruction=0; instrValid, fetchFault, running, noProgram, wrAck and wrReject all =0; activeBank=0.
  - Memory contents are not cleared by reset. Simulation initialises them to 0.
- FSM states: IDLE, RUN.
  - IDLE + start + |programSelect: activeBank <= index of lowest set bit; next state RUN; running=1 from the next cycle.
  - IDLE + start + programSelect==0: stay in IDLE; noProgram pulses next cycle.
  - RUN + halt: go to IDLE; activeBank holds its last value.
  - RUN + start alone: ignored.
  - start and halt in the same cycle while in RUN: halt wins.
  - programSelect changes while in RUN: ignored.
- Fetch (latency 1): the cycle after fetchReq, instrValid=1 and instruction holds the result.
  - Normal fetch (RUN, fetchAddr<DEPTH): instruction=mem[activeBank][fetchAddr], fetchFault=0.
  - Faulted fetch (fetchAddr>=DEPTH, or state IDLE): instruction=HALT_WORD, fetchFault=1.
  - Back-to-back fetchReq is supported, one result per cycle.
  - instruction holds its last value when instrValid=0.
  - A fetch issued in the same cycle as halt still uses RUN-state rules.
- Write (latency 1): the cycle after wrEn, exactly one of wrAck or wrReject pulses.
  - Reject if wrAddr>=DEPTH.
  - Reject if wrBank>=NUM_BANKS.
  - Reject if running and wrBank==activeBank, i.e. no self-modifying the live program.
  - Otherwise mem[wrBank][wrAddr] <= wrData.
  - A write and a fetch to different banks in the same cycle are both serviced.
  - A write accepted in IDLE is visible to the first fetch after the following start.
- Reset asserted mid-operation: any pending instrValid, wrAck, wrReject and noProgram pulses are dropped. A write being committed at the reset edge may be lost; the write is either fully done or not done.
- Width rules:
  - fetchAddr is compared against DEPTH at full width, with no wrap-around.
  - Bank index width is clog2(NUM_BANKS), with a minimum of 1.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode localparams: SET=0000, LOAD_IN=0001, COPY=0010, ADD=0100, NEG=0101, AND=0110, OR=0111, SHL=1000, GT=1011, JMPIF=1100, HALT=1110;
  - HALT_WORD;
  - the state enum typedef {IDLE, RUN}.
- One sub-module, priority_bank_encoder (NUM_BANKS-wide one-hot-ish input -> index plus any-set flag). It replaces the hand-written priority chain.
- Storage is a single flattened array of NUM_BANKS*DEPTH words, indexed {bank, addr}.

Test Plan:
- Load bank2 words 0..2 = 0201,2F10,E000 in IDLE; select 8'b0000_0100, start; fetch addr 0,1,2 back-to-back -> instrValid on 3 consecutive cycles with 0201, 2F10, E000; fetchFault=0.
- programSelect=8'b0000_0110, start -> activeBank=1; change select to 8'b1 mid-RUN -> activeBank stays 1 until halt.
- start with programSelect=0 -> noProgram pulse, running stays 0. Fetch in IDLE -> E000 with fetchFault=1.
- In RUN on bank1: write bank1 addr 5 -> wrReject. Write bank3 addr 5 -> wrAck. Write addr 200 (DEPTH=128) -> wrReject.
- Fetch addr 128 in RUN -> instruction=E000, fetchFault=1. Same cycle start+halt in RUN -> IDLE next cycle.
- Assert rstN low one cycle after fetchReq -> instrValid never pulses, all outputs 0. Memory contents are retained after reset, checked by refetching.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared CPU ISA definitions: opcodes, the HALT instruction word and the
// program-store run state.
package cpu_isa_pkg;

  localparam logic [3:0] OP_SET     = 4'b0000;
  localparam logic [3:0] OP_LOAD_IN = 4'b0001;
  localparam logic [3:0] OP_COPY    = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_NEG     = 4'b0101;
  localparam logic [3:0] OP_AND     = 4'b0110;
  localparam logic [3:0] OP_OR      = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1000;
  localparam logic [3:0] OP_GT      = 4'b1011;
  localparam logic [3:0] OP_JMPIF   = 4'b1100;
  localparam logic [3:0] OP_HALT    = 4'b1110;

  localparam logic [15:0] HALT_WORD = {OP_HALT, 12'h000};

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/banked_instruction_memory_if.sv
// Fetch, control and program-load bus between the CPU side (master) and the
// banked program store (slave).
interface banked_instruction_memory_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_BANKS   = 8,
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
);

  logic [NUM_BANKS-1:0]   programSelect;
  logic                   start;
  logic                   halt;
  logic                   fetchReq;
  logic [ADDR_WIDTH-1:0]  fetchAddr;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instrValid;
  logic                   fetchFault;
  logic                   running;
  logic [BANK_W-1:0]      activeBank;
  logic                   noProgram;
  logic                   wrEn;
  logic [BANK_W-1:0]      wrBank;
  logic [ADDR_WIDTH-1:0]  wrAddr;
  logic [INSTR_WIDTH-1:0] wrData;
  logic                   wrAck;
  logic                   wrReject;

  modport master (
    output programSelect, start, halt, fetchReq, fetchAddr,
    output wrEn, wrBank, wrAddr, wrData,
    input  instruction, instrValid, fetchFault, running, activeBank, noProgram,
    input  wrAck, wrReject
  );

  modport slave (
    input  programSelect, start, halt, fetchReq, fetchAddr,
    input  wrEn, wrBank, wrAddr, wrData,
    output instruction, instrValid, fetchFault, running, activeBank, noProgram,
    output wrAck, wrReject
  );

endinterface

// File: rtl/banked_instruction_memory_priority_bank_encoder.sv
// Lowest-index-wins priority encoder over the bank select vector.
module priority_bank_encoder #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_BANKS-1:0] req_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Walk downward so the lowest set bit is the last one assigned.
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/banked_instruction_memory.sv
// Multi-bank writable program store: latches one bank for the run, serves
// one-cycle registered fetches and acknowledges/rejects program loads.
module banked_instruction_memory #(
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     ADDR_WIDTH  = 8,
  parameter int                     DEPTH       = 128,
  parameter int                     NUM_BANKS   = 8,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = INSTR_WIDTH'(cpu_isa_pkg::HALT_WORD)
) (
  input logic                    clk,
  input logic                    rstN,
  banked_instruction_memory_if.slave bus
);
  import cpu_isa_pkg::*;

  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int MEM_WORDS = NUM_BANKS * DEPTH;
  localparam int MEM_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Limits one bit wider than the operands so comparisons never wrap.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [BANK_W:0]     BANK_LIM  = (BANK_W + 1)'(NUM_BANKS);

  logic [INSTR_WIDTH-1:0] mem_q [MEM_WORDS];

  state_t                 state_q;
  logic [BANK_W-1:0]      bank_q;
  logic                   running_q;
  logic                   noprog_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   ivld_q;
  logic                   fault_q;
  logic                   wack_q;
  logic                   wrej_q;

  logic [BANK_W-1:0]      sel_idx;
  logic                   sel_any;
  logic                   rd_ok;
  logic                   wr_ok;
  logic [MEM_W-1:0]       rd_idx;
  logic [MEM_W-1:0]       wr_idx;
  logic [INSTR_WIDTH-1:0] instr_d;

  function automatic logic [MEM_W-1:0] flat_idx(input logic [BANK_W-1:0]     b,
                                               input logic [ADDR_WIDTH-1:0] a);
    return MEM_W'(int'(b) * DEPTH + int'(a));
  endfunction

  priority_bank_encoder #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (BANK_W)
  ) u_enc (
    .req_i (bus.programSelect),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  always_comb begin
    rd_ok   = (state_q == RUN) && ({1'b0, bus.fetchAddr} < DEPTH_LIM);
    rd_idx  = rd_ok ? flat_idx(bank_q, bus.fetchAddr) : '0;
    instr_d = rd_ok ? mem_q[rd_idx] : HALT_WORD;
    // The live program cannot be modified while it runs.
    wr_ok   = ({1'b0, bus.wrAddr} < DEPTH_LIM) &&
              ({1'b0, bus.wrBank} < BANK_LIM) &&
              !(running_q && (bus.wrBank == bank_q));
    wr_idx  = wr_ok ? flat_idx(bus.wrBank, bus.wrAddr) : '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      running_q <= 1'b0;
      noprog_q  <= 1'b0;
      instr_q   <= '0;
      ivld_q    <= 1'b0;
      fault_q   <= 1'b0;
      wack_q    <= 1'b0;
      wrej_q    <= 1'b0;
    end else begin
      noprog_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (sel_any) begin
              state_q   <= RUN;
              bank_q    <= sel_idx;
              running_q <= 1'b1;
            end else begin
              noprog_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.halt) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      ivld_q <= bus.fetchReq;
      if (bus.fetchReq) begin
        instr_q <= instr_d;
        fault_q <= !rd_ok;
      end

      wack_q <= bus.wrEn && wr_ok;
      wrej_q <= bus.wrEn && !wr_ok;
    end
  end

  // Storage has no reset; contents survive rstN.
  always_ff @(posedge clk) begin
    if (bus.wrEn && wr_ok) mem_q[wr_idx] <= bus.wrData;
  end

  assign bus.instruction = instr_q;
  assign bus.instrValid  = ivld_q;
  assign bus.fetchFault  = fault_q;
  assign bus.running     = running_q;
  assign bus.activeBank  = bank_q;
  assign bus.noProgram   = noprog_q;
  assign bus.wrAck       = wack_q;
  assign bus.wrReject    = wrej_q;

endmodule

// File: tb/tb_banked_instruction_memory.sv
// Directed bench for banked_instruction_memory: load, select, fetch, write
// protection, fault and reset scenarios with hand-computed expectations.
module tb_banked_instruction_memory;

  localparam int INSTR_WIDTH = 16;
  localparam int ADDR_WIDTH  = 8;
  localparam int DEPTH       = 128;
  localparam int NUM_BANKS   = 8;

  logic clk;
  logic rstN;
  int   errors;
  int   checks;

  banked_instruction_memory_if #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_BANKS   (NUM_BANKS)
  ) bus ();

  banked_instruction_memory #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH),
    .NUM_BANKS   (NUM_BANKS),
    .HALT_WORD   (16'hE000)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.programSelect = '0;
    bus.start         = 1'b0;
    bus.halt          = 1'b0;
    bus.fetchReq      = 1'b0;
    bus.fetchAddr     = '0;
    bus.wrEn          = 1'b0;
    bus.wrBank        = '0;
    bus.wrAddr        = '0;
    bus.wrData        = '0;
  endtask

  task automatic drive_write(input logic [2:0] b, input logic [7:0] a, input logic [15:0] d);
    bus.wrEn = 1'b1; bus.wrBank = b; bus.wrAddr = a; bus.wrData = d;
    step();
    bus.wrEn = 1'b0;
  endtask

  task automatic drive_fetch(input logic [7:0] a);
    bus.fetchReq = 1'b1; bus.fetchAddr = a;
    step();
    bus.fetchReq = 1'b0;
  endtask

  task automatic drive_start(input logic [7:0] sel);
    bus.programSelect = sel; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if ({bus.instruction, bus.instrValid, bus.fetchFault, bus.running, bus.activeBank,
         bus.noProgram, bus.wrAck, bus.wrReject} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got instr=%h vld=%b flt=%b run=%b bank=%0d nop=%b ack=%b rej=%b exp all 0",
               bus.instruction, bus.instrValid, bus.fetchFault, bus.running, bus.activeBank,
               bus.noProgram, bus.wrAck, bus.wrReject);
    end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_load_fetch();
    logic [15:0] words [3];
    words[0] = 16'h0201; words[1] = 16'h2F10; words[2] = 16'hE000;
    for (int i = 0; i < 3; i++) begin
      drive_write(3'd2, 8'(i), words[i]);
      checks++;
      if (bus.wrAck !== 1'b1 || bus.wrReject !== 1'b0) begin
        errors++;
        $display("FAIL load_ack[%0d] got ack=%b rej=%b exp ack=1 rej=0", i, bus.wrAck, bus.wrReject);
      end
    end
    drive_write(3'd1, 8'd0, 16'h4321);
    step();
    checks++;
    if (bus.wrAck !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse got=%b exp=0", bus.wrAck);
    end
    drive_start(8'b0000_0100);
    checks++;
    if (bus.running !== 1'b1 || bus.activeBank !== 3'd2) begin
      errors++;
      $display("FAIL start_bank2 got run=%b bank=%0d exp run=1 bank=2", bus.running, bus.activeBank);
    end
    bus.fetchReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetchAddr = 8'(i);
      step();
      checks++;
      if (bus.instrValid !== 1'b1 || bus.instruction !== words[i] || bus.fetchFault !== 1'b0) begin
        errors++;
        $display("FAIL b2b_fetch[%0d] got vld=%b instr=%h flt=%b exp vld=1 instr=%h flt=0",
                 i, bus.instrValid, bus.instruction, bus.fetchFault, words[i]);
      end
    end
    bus.fetchReq = 1'b0;
    bus.fetchAddr = 8'd1;
    step();
    checks++;
    if (bus.instrValid !== 1'b0 || bus.instruction !== 16'hE000) begin
      errors++;
      $display("FAIL instr_hold got vld=%b instr=%h exp vld=0 instr=e000", bus.instrValid, bus.instruction);
    end
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    checks++;
    if (bus.running !== 1'b0 || bus.activeBank !== 3'd2) begin
      errors++;
      $display("FAIL halt_hold got run=%b bank=%0d exp run=0 bank=2", bus.running, bus.activeBank);
    end
  endtask

  task automatic test_select_priority();
    drive_start(8'b0000_0110);
    checks++;
    if (bus.running !== 1'b1 || bus.activeBank !== 3'd1) begin
      errors++;
      $display("FAIL prio_sel got run=%b bank=%0d exp run=1 bank=1", bus.running, bus.activeBank);
    end
    drive_start(8'b0000_0001);
    step();
    checks++;
    if (bus.running !== 1'b1 || bus.activeBank !== 3'd1) begin
      errors++;
      $display("FAIL sel_change_in_run got run=%b bank=%0d exp run=1 bank=1", bus.running, bus.activeBank);
    end
  endtask

  task automatic test_write_rules();
    drive_write(3'd1, 8'd5, 16'hAAAA);
    checks++;
    if (bus.wrAck !== 1'b0 || bus.wrReject !== 1'b1) begin
      errors++;
      $display("FAIL wr_live_bank got ack=%b rej=%b exp ack=0 rej=1", bus.wrAck, bus.wrReject);
    end
    drive_write(3'd3, 8'd5, 16'h1234);
    checks++;
    if (bus.wrAck !== 1'b1 || bus.wrReject !== 1'b0) begin
      errors++;
      $display("FAIL wr_other_bank got ack=%b rej=%b exp ack=1 rej=0", bus.wrAck, bus.wrReject);
    end
    drive_write(3'd3, 8'd200, 16'h9999);
    checks++;
    if (bus.wrAck !== 1'b0 || bus.wrReject !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr_range got ack=%b rej=%b exp ack=0 rej=1", bus.wrAck, bus.wrReject);
    end
    bus.wrEn = 1'b1; bus.wrBank = 3'd3; bus.wrAddr = 8'd6; bus.wrData = 16'h5678;
    bus.fetchReq = 1'b1; bus.fetchAddr = 8'd0;
    step();
    bus.wrEn = 1'b0; bus.fetchReq = 1'b0;
    checks++;
    if (bus.wrAck !== 1'b1 || bus.instrValid !== 1'b1 || bus.instruction !== 16'h4321 || bus.fetchFault !== 1'b0) begin
      errors++;
      $display("FAIL wr_and_fetch got ack=%b vld=%b instr=%h flt=%b exp ack=1 vld=1 instr=4321 flt=0",
               bus.wrAck, bus.instrValid, bus.instruction, bus.fetchFault);
    end
    drive_fetch(8'd128);
    checks++;
    if (bus.instrValid !== 1'b1 || bus.instruction !== 16'hE000 || bus.fetchFault !== 1'b1) begin
      errors++;
      $display("FAIL fetch_oob got vld=%b instr=%h flt=%b exp vld=1 instr=e000 flt=1",
               bus.instrValid, bus.instruction, bus.fetchFault);
    end
    bus.start = 1'b1; bus.halt = 1'b1; bus.fetchReq = 1'b1; bus.fetchAddr = 8'd0;
    step();
    bus.start = 1'b0; bus.halt = 1'b0; bus.fetchReq = 1'b0;
    checks++;
    if (bus.running !== 1'b0 || bus.instruction !== 16'h4321 || bus.fetchFault !== 1'b0) begin
      errors++;
      $display("FAIL start_halt_fetch got run=%b instr=%h flt=%b exp run=0 instr=4321 flt=0",
               bus.running, bus.instruction, bus.fetchFault);
    end
    drive_start(8'b0000_1000);
    drive_fetch(8'd5);
    checks++;
    if (bus.activeBank !== 3'd3 || bus.instruction !== 16'h1234) begin
      errors++;
      $display("FAIL bank3_word5 got bank=%0d instr=%h exp bank=3 instr=1234", bus.activeBank, bus.instruction);
    end
    drive_fetch(8'd6);
    checks++;
    if (bus.instruction !== 16'h5678) begin
      errors++;
      $display("FAIL bank3_word6 got instr=%h exp instr=5678", bus.instruction);
    end
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
  endtask

  task automatic test_no_program();
    drive_start(8'b0000_0000);
    checks++;
    if (bus.noProgram !== 1'b1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL noprog_pulse got nop=%b run=%b exp nop=1 run=0", bus.noProgram, bus.running);
    end
    step();
    checks++;
    if (bus.noProgram !== 1'b0) begin
      errors++;
      $display("FAIL noprog_clear got=%b exp=0", bus.noProgram);
    end
    drive_fetch(8'd0);
    checks++;
    if (bus.instrValid !== 1'b1 || bus.instruction !== 16'hE000 || bus.fetchFault !== 1'b1) begin
      errors++;
      $display("FAIL fetch_idle got vld=%b instr=%h flt=%b exp vld=1 instr=e000 flt=1",
               bus.instrValid, bus.instruction, bus.fetchFault);
    end
  endtask

  task automatic test_reset_mid();
    drive_start(8'b0000_0100);
    bus.fetchReq = 1'b1; bus.fetchAddr = 8'd1;
    #2 rstN = 1'b0;
    step();
    bus.fetchReq = 1'b0;
    checks++;
    if ({bus.instruction, bus.instrValid, bus.fetchFault, bus.running, bus.activeBank,
         bus.noProgram, bus.wrAck, bus.wrReject} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got instr=%h vld=%b flt=%b run=%b bank=%0d exp all 0",
               bus.instruction, bus.instrValid, bus.fetchFault, bus.running, bus.activeBank);
    end
    rstN = 1'b1;
    step();
    checks++;
    if (bus.instrValid !== 1'b0 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got vld=%b run=%b exp vld=0 run=0", bus.instrValid, bus.running);
    end
    drive_start(8'b0000_0100);
    drive_fetch(8'd1);
    checks++;
    if (bus.instrValid !== 1'b1 || bus.instruction !== 16'h2F10 || bus.fetchFault !== 1'b0) begin
      errors++;
      $display("FAIL mem_retained got vld=%b instr=%h flt=%b exp vld=1 instr=2f10 flt=0",
               bus.instrValid, bus.instruction, bus.fetchFault);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_fetch();
    test_select_priority();
    test_write_rules();
    test_no_program();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
